vga_stream_receiver: RTL
========================

# vga_stream_receiver

Receives the VGA output interface of the video system (HS, VS, BLANK, 8-bit R/G/B on the pixel clock) and converts it back into a coordinate-tagged pixel stream. Measures each frame's active geometry and reports lock and error status. Used as the checking and capture end of the VGA link, for loopback verification and frame capture into the processing pipeline.

## Interface
- H_ACTIVE, 640, expected active pixels per line
- V_ACTIVE, 480, expected active lines per frame
- XW, 10, width of x counter and measured width
- YW, 10, width of y counter and measured height
- clk_clk  in  1  pixel clock; all logic on rising edge
- reset_reset  in  1  asynchronous, active-high reset
- vga_hs  in  1  horizontal sync, active low
- vga_vs  in  1  vertical sync, active low
- vga_blank  in  1  BLANK_N: 1 = active video, 0 = blanking
- vga_r, vga_g, vga_b  in  8 each  colour components
- pix_valid  out  1  pixel strobe
- pix_data  out  24  {R,G,B}
- pix_x  out  XW  column of pixel
- pix_y  out  YW  line of pixel
- pix_sof  out  1  with pix_valid at (0,0)
- pix_eol  out  1  with pix_valid at x = H_ACTIVE-1
- frame_done  out  1  one-cycle pulse at end of a frame
- meas_width  out  XW  active pixel count of last completed line
- meas_height  out  YW  active line count of last completed frame
- frame_err  out  1  valid at frame_done; 1 = last frame malformed
- locked  out  1  last completed frame was error-free and exact size

## Operation
- Stage 1 registers all vga_* inputs. Edges are detected against a second copy: VS fall, BLANK rise (line start), BLANK fall (line end), HS fall.
- States:
  - IDLE (reset): no pixels emitted; on VS fall go to FRAME.
  - FRAME: pixel processing active.
- VS fall in FRAME ends the current frame:
  - frame_done=1.
  - meas_height <= ycnt.
  - frame_err <= err_acc OR (ycnt != V_ACTIVE).
  - locked <= NOT that error.
- On every VS fall (from IDLE or FRAME):
  - xcnt=0, ycnt=0, err_acc=0.
  - The first VS fall after reset produces no frame_done.
- Active cycle (registered BLANK_N=1) in FRAME:
  - If xcnt < H_ACTIVE and ycnt < V_ACTIVE: pix_valid=1, pix_data/x/y from current sample and counters.
  - Otherwise: pixel dropped and err_acc set.
  - xcnt increments, saturating at 2^XW-1.
- BLANK fall in FRAME:
  - meas_width <= xcnt.
  - err_acc set if xcnt != H_ACTIVE.
  - ycnt increments (saturating); xcnt=0.
- HS fall while BLANK_N=1 sets err_acc. HS is otherwise unused.
- VS fall while BLANK_N=1 (line in progress):
  - Partial line is discarded and not counted in ycnt; the frame ends with frame_err=1.
  - If the same cycle is active, that pixel is emitted as (0,0) of the new frame with pix_sof.
- Reset values: every output 0; state IDLE; counters and err_acc 0.
- Reset mid-frame returns to IDLE immediately. Nothing is emitted until the next VS fall.

## Timing
- Latency: input sample at edge N appears on pix_* after edge N+2 (input register plus output register).
- pix_valid, pix_sof, pix_eol and frame_done are single-cycle strobes. There is no backpressure; the consumer must accept one pixel per clock.
- frame_done, meas_height, frame_err and locked update in the same cycle, 2 cycles after the VS fall sample.
- meas_width updates 2 cycles after the BLANK fall sample.
- pix_sof and pix_eol never assert without pix_valid.
- Within a line, consecutive active samples give consecutive pix_x values with no gaps.

## Test plan
- Nominal 640x480 timing (800x525 totals), three frames:
  - Every frame: 307200 pix_valid pulses; sof at (0,0); eol at x=639.
  - frame_done on frames 2 and 3 with meas_width=640, meas_height=480, frame_err=0, locked=1.
  - No frame_done for the first VS.
- One line with 641 active cycles:
  - Pixel x=640 dropped.
  - meas_width=641 after that line.
  - At next frame_done: frame_err=1, locked=0.
  - Following clean frame: locked=1.
- Frame with 479 lines: meas_height=479, frame_err=1, locked=0.
- VS fall at x=300 of line 100:
  - Frame ends with meas_height=100, frame_err=1.
  - Concurrent active pixel emitted as (0,0) with pix_sof.
- Data and latency check: ramp pixel data = {x[7:0], y[7:0], 8'hA5}.
  - Every pix_data matches its pix_x/pix_y.
  - Latency exactly 2 cycles.
- Reset asserted mid-line:
  - All outputs 0 immediately.
  - No pix_valid until after the next VS fall.
  - First frame_done only at the second VS fall.

Source files
------------

// File: rtl/vga_stream_receiver.sv
// rtl/vga_stream_receiver.sv - VGA capture back into a coordinate-tagged pixel stream
module vga_stream_receiver #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          clk_clk,
  input  logic          reset_reset,
  input  logic          vga_hs,
  input  logic          vga_vs,
  input  logic          vga_blank,
  input  logic [7:0]    vga_r,
  input  logic [7:0]    vga_g,
  input  logic [7:0]    vga_b,
  output logic          pix_valid,
  output logic [23:0]   pix_data,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          frame_done,
  output logic [XW-1:0] meas_width,
  output logic [YW-1:0] meas_height,
  output logic          frame_err,
  output logic          locked
);

  typedef enum logic {IDLE, FRAME} state_t;

  localparam logic [XW-1:0] H_LIM  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] V_LIM  = YW'(V_ACTIVE);
  localparam logic [XW-1:0] X_MAX  = '1;
  localparam logic [YW-1:0] Y_MAX  = '1;

  state_t        state_q;
  logic          hs1_q, vs1_q, blank1_q;
  logic          hs2_q, vs2_q, blank2_q;
  logic [23:0]   rgb1_q;
  logic [XW-1:0] xcnt_q;
  logic [YW-1:0] ycnt_q;
  logic          err_q;

  logic          pix_valid_q, pix_sof_q, pix_eol_q, frame_done_q;
  logic [23:0]   pix_data_q;
  logic [XW-1:0] pix_x_q, meas_width_q;
  logic [YW-1:0] pix_y_q, meas_height_q;
  logic          frame_err_q, locked_q;

  logic          vs_fall, blank_fall, hs_fall, frame_bad;
  logic [XW-1:0] xcnt_d;
  logic [YW-1:0] ycnt_d;

  always_comb begin
    vs_fall    = vs2_q & ~vs1_q;
    blank_fall = blank2_q & ~blank1_q;
    hs_fall    = hs2_q & ~hs1_q;
    // a line still active when VS falls means the frame was cut short
    frame_bad  = err_q | (ycnt_q != V_LIM) | blank1_q;
    xcnt_d     = (xcnt_q == X_MAX) ? xcnt_q : xcnt_q + 1'b1;
    ycnt_d     = (ycnt_q == Y_MAX) ? ycnt_q : ycnt_q + 1'b1;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q       <= IDLE;
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      blank1_q      <= 1'b0;
      hs2_q         <= 1'b0;
      vs2_q         <= 1'b0;
      blank2_q      <= 1'b0;
      rgb1_q        <= '0;
      xcnt_q        <= '0;
      ycnt_q        <= '0;
      err_q         <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_sof_q     <= 1'b0;
      pix_eol_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      pix_data_q    <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      meas_width_q  <= '0;
      meas_height_q <= '0;
      frame_err_q   <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      hs1_q        <= vga_hs;
      vs1_q        <= vga_vs;
      blank1_q     <= vga_blank;
      rgb1_q       <= {vga_r, vga_g, vga_b};
      hs2_q        <= hs1_q;
      vs2_q        <= vs1_q;
      blank2_q     <= blank1_q;
      pix_valid_q  <= 1'b0;
      pix_sof_q    <= 1'b0;
      pix_eol_q    <= 1'b0;
      frame_done_q <= 1'b0;

      if (vs_fall) begin
        if (state_q == FRAME) begin
          frame_done_q  <= 1'b1;
          meas_height_q <= ycnt_q;
          frame_err_q   <= frame_bad;
          locked_q      <= ~frame_bad;
        end
        state_q <= FRAME;
        ycnt_q  <= '0;
        err_q   <= 1'b0;
        // an active sample coincident with VS fall opens the new frame
        if (blank1_q) begin
          pix_valid_q <= 1'b1;
          pix_data_q  <= rgb1_q;
          pix_x_q     <= '0;
          pix_y_q     <= '0;
          pix_sof_q   <= 1'b1;
          pix_eol_q   <= (H_ACTIVE == 1);
          xcnt_q      <= XW'(1);
        end else begin
          xcnt_q <= '0;
        end
      end else if (state_q == FRAME) begin
        if (blank_fall) begin
          meas_width_q <= xcnt_q;
          if (xcnt_q != H_LIM) err_q <= 1'b1;
          ycnt_q <= ycnt_d;
          xcnt_q <= '0;
        end else if (blank1_q) begin
          if (xcnt_q < H_LIM && ycnt_q < V_LIM) begin
            pix_valid_q <= 1'b1;
            pix_data_q  <= rgb1_q;
            pix_x_q     <= xcnt_q;
            pix_y_q     <= ycnt_q;
            pix_sof_q   <= (xcnt_q == '0) && (ycnt_q == '0);
            pix_eol_q   <= (xcnt_q == H_LAST);
          end else begin
            err_q <= 1'b1;
          end
          if (hs_fall) err_q <= 1'b1;
          xcnt_q <= xcnt_d;
        end
      end
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_sof     = pix_sof_q;
  assign pix_eol     = pix_eol_q;
  assign frame_done  = frame_done_q;
  assign meas_width  = meas_width_q;
  assign meas_height = meas_height_q;
  assign frame_err   = frame_err_q;
  assign locked      = locked_q;

endmodule
